// File: rtl/muldiv_ctrl_if.sv
// rtl/muldiv_ctrl_if.sv - execute-stage request/response bus for the mul/div sequencer
interface muldiv_ctrl_if #(
    parameter int XLEN = 64
);
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_op;
    logic            req_word;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_data;
    logic            flush;

    // Execute stage: issues ops, consumes results, kills in-flight work
    modport master (
        output req_valid, req_op, req_word, req_a, req_b, resp_ready, flush,
        input  req_ready, resp_valid, resp_data
    );

    // Sequencer side
    modport slave (
        input  req_valid, req_op, req_word, req_a, req_b, resp_ready, flush,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - sequencer around the shared iterative multiply/divide unit
module muldiv_ctrl #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    muldiv_ctrl_if.slave    bus,
    output logic            unit_start,
    output logic            unit_abort,
    output logic            unit_div,
    output logic [XLEN-1:0] unit_a,
    output logic [XLEN-1:0] unit_b,
    input  logic            unit_done,
    input  logic [XLEN-1:0] unit_lo,
    input  logic [XLEN-1:0] unit_hi
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_REM    = 3'd6;

    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] X_MIN    = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] W_MIN    = {{(XLEN-32){1'b1}}, 32'h8000_0000};

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
        return {{(XLEN-32){1'b0}}, v};
    endfunction

    state_t          state_q,      state_d;
    logic [2:0]      op_q,         op_d;
    logic            word_q,       word_d;
    logic            a_neg_q,      a_neg_d;
    logic            b_neg_q,      b_neg_d;
    logic            unit_start_q, unit_start_d;
    logic            unit_abort_q, unit_abort_d;
    logic            unit_div_q,   unit_div_d;
    logic [XLEN-1:0] unit_a_q,     unit_a_d;
    logic [XLEN-1:0] unit_b_q,     unit_b_d;
    logic            resp_valid_q, resp_valid_d;
    logic [XLEN-1:0] resp_data_q,  resp_data_d;

    // Request decode: operand extension, magnitudes and the special cases
    logic            in_word;
    logic            in_a_signed;
    logic            in_b_signed;
    logic [XLEN-1:0] a_ext;
    logic [XLEN-1:0] b_ext;
    logic            in_a_neg;
    logic            in_b_neg;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] special_res;

    // Decode the presented request into what the unit needs and detect shortcut results
    always_comb begin
        // MULH/MULHSU/MULHU have no W form; a stray word bit is ignored for them
        in_word     = bus.req_word & ((bus.req_op == OP_MUL) | bus.req_op[2]);
        in_a_signed = (bus.req_op == OP_MUL) | (bus.req_op == OP_MULH) |
                      (bus.req_op == OP_MULHSU) | (bus.req_op == OP_DIV) |
                      (bus.req_op == OP_REM);
        in_b_signed = (bus.req_op == OP_MUL) | (bus.req_op == OP_MULH) |
                      (bus.req_op == OP_DIV) | (bus.req_op == OP_REM);

        a_ext = bus.req_a;
        b_ext = bus.req_b;
        if (in_word) begin
            a_ext = in_a_signed ? sext32(bus.req_a[31:0]) : zext32(bus.req_a[31:0]);
            b_ext = in_b_signed ? sext32(bus.req_b[31:0]) : zext32(bus.req_b[31:0]);
        end

        in_a_neg = in_a_signed & a_ext[XLEN-1];
        in_b_neg = in_b_signed & b_ext[XLEN-1];
        mag_a    = in_a_neg ? (~a_ext + 1'b1) : a_ext;
        mag_b    = in_b_neg ? (~b_ext + 1'b1) : b_ext;

        div_zero = bus.req_op[2] & (b_ext == '0);
        div_ovf  = ((bus.req_op == OP_DIV) | (bus.req_op == OP_REM)) &
                   (a_ext == (in_word ? W_MIN : X_MIN)) & (b_ext == ALL_ONES);

        special_res = '0;
        if (div_zero) begin
            // Quotient by zero is all ones; remainder by zero is the dividend
            if (!bus.req_op[1]) begin
                special_res = ALL_ONES;
            end else begin
                special_res = in_word ? sext32(bus.req_a[31:0]) : bus.req_a;
            end
        end else if (div_ovf) begin
            special_res = bus.req_op[1] ? '0 : (in_word ? W_MIN : X_MIN);
        end
    end

    // Result fix-up applied to the raw unsigned unit output
    logic [2*XLEN-1:0] prod_raw;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   res_full;
    logic [XLEN-1:0]   res_final;

    // Restore signs on the unit result and select the architectural value
    always_comb begin
        prod_raw = {unit_hi, unit_lo};
        prod_fix = (a_neg_q ^ b_neg_q) ? (~prod_raw + 1'b1) : prod_raw;
        quo_fix  = (a_neg_q ^ b_neg_q) ? (~unit_lo + 1'b1) : unit_lo;
        rem_fix  = a_neg_q ? (~unit_hi + 1'b1) : unit_hi;

        res_full = '0;
        if (op_q[2]) begin
            res_full = op_q[1] ? rem_fix : quo_fix;
        end else if (op_q == OP_MUL) begin
            res_full = prod_fix[XLEN-1:0];
        end else begin
            res_full = prod_fix[2*XLEN-1:XLEN];
        end
        res_final = word_q ? sext32(res_full[31:0]) : res_full;
    end

    // Next-state and registered-output computation; flush overrides everything
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        word_d       = word_q;
        a_neg_d      = a_neg_q;
        b_neg_d      = b_neg_q;
        unit_start_d = 1'b0;
        unit_abort_d = 1'b0;
        unit_div_d   = unit_div_q;
        unit_a_d     = unit_a_q;
        unit_b_d     = unit_b_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;

        if (bus.flush) begin
            state_d      = IDLE;
            resp_valid_d = 1'b0;
            unit_abort_d = (state_q == START) | (state_q == WAIT);
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        op_d    = bus.req_op;
                        word_d  = in_word;
                        a_neg_d = in_a_neg;
                        b_neg_d = in_b_neg;
                        if (div_zero | div_ovf) begin
                            state_d      = RESP;
                            resp_valid_d = 1'b1;
                            resp_data_d  = special_res;
                        end else begin
                            state_d      = START;
                            unit_start_d = 1'b1;
                            unit_div_d   = bus.req_op[2];
                            unit_a_d     = mag_a;
                            unit_b_d     = mag_b;
                        end
                    end
                end
                START: begin
                    state_d = WAIT;
                end
                WAIT: begin
                    if (unit_done) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_data_d  = res_final;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state_d      = IDLE;
                        resp_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Single state/output register bank with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            op_q         <= '0;
            word_q       <= 1'b0;
            a_neg_q      <= 1'b0;
            b_neg_q      <= 1'b0;
            unit_start_q <= 1'b0;
            unit_abort_q <= 1'b0;
            unit_div_q   <= 1'b0;
            unit_a_q     <= '0;
            unit_b_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            word_q       <= word_d;
            a_neg_q      <= a_neg_d;
            b_neg_q      <= b_neg_d;
            unit_start_q <= unit_start_d;
            unit_abort_q <= unit_abort_d;
            unit_div_q   <= unit_div_d;
            unit_a_q     <= unit_a_d;
            unit_b_q     <= unit_b_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    // Ready is held low while reset is asserted even though the state reads IDLE
    assign bus.req_ready  = (state_q == IDLE) & ~reset;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign unit_start     = unit_start_q;
    assign unit_abort     = unit_abort_q;
    assign unit_div       = unit_div_q;
    assign unit_a         = unit_a_q;
    assign unit_b         = unit_b_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - directed self-checking bench for muldiv_ctrl
module tb_muldiv_ctrl;

    localparam int XLEN = 64;

    logic            clk;
    logic            reset;
    logic            unit_start;
    logic            unit_abort;
    logic            unit_div;
    logic [XLEN-1:0] unit_a;
    logic [XLEN-1:0] unit_b;
    logic            unit_done;
    logic [XLEN-1:0] unit_lo;
    logic [XLEN-1:0] unit_hi;

    logic            auto_done;
    logic            man_done;
    logic            model_en;
    logic            start_seen;
    int              start_cnt;
    logic [XLEN-1:0] cap_a;
    logic [XLEN-1:0] cap_b;
    logic [XLEN-1:0] mdl_lo;
    logic [XLEN-1:0] mdl_hi;

    int total;
    int bad;

    muldiv_ctrl_if #(.XLEN(XLEN)) bus ();

    muldiv_ctrl #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .unit_start (unit_start),
        .unit_abort (unit_abort),
        .unit_div   (unit_div),
        .unit_a     (unit_a),
        .unit_b     (unit_b),
        .unit_done  (unit_done),
        .unit_lo    (unit_lo),
        .unit_hi    (unit_hi)
    );

    assign unit_done = auto_done | man_done;
    assign unit_lo   = mdl_lo;
    assign unit_hi   = mdl_hi;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unit stand-in: done one cycle after start, counts starts and captures operands
    always @(negedge clk) begin
        auto_done  = start_seen & model_en;
        start_seen = unit_start;
        if (unit_start) begin
            start_cnt = start_cnt + 1;
            cap_a     = unit_a;
            cap_b     = unit_b;
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_accept(input string tag);
        int n;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val({tag, " accept"}, 64'(bus.req_ready), 64'd1);
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic w,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] lo, input logic [63:0] hi,
                          input logic [63:0] exp, input int exp_starts, input int exp_lat);
        int n;
        int s0;
        @(negedge clk);
        mdl_lo        = lo;
        mdl_hi        = hi;
        s0            = start_cnt;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_word  = w;
        bus.req_a     = a;
        bus.req_b     = b;
        wait_accept(tag);
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 1;
        while (!bus.resp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_val({tag, " latency"}, 64'(n), 64'(exp_lat));
        check_val({tag, " data"}, bus.resp_data, exp);
        check_val({tag, " starts"}, 64'(start_cnt - s0), 64'(exp_starts));
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        check_val({tag, " drained"}, {62'd0, bus.resp_valid, bus.req_ready}, 64'd1);
    endtask

    initial begin
        int s0;
        total          = 0;
        bad            = 0;
        start_cnt      = 0;
        start_seen     = 1'b0;
        auto_done      = 1'b0;
        man_done       = 1'b0;
        model_en       = 1'b1;
        cap_a          = '0;
        cap_b          = '0;
        mdl_lo         = '0;
        mdl_hi         = '0;
        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_op     = 3'd0;
        bus.req_word   = 1'b0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 1'b0;
        bus.flush      = 1'b0;

        repeat (3) @(negedge clk);
        check_val("reset outs", {59'd0, bus.req_ready, bus.resp_valid, unit_start, unit_abort, unit_div}, 64'd0);
        check_val("reset data", bus.resp_data, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check_val("ready after reset", 64'(bus.req_ready), 64'd1);

        // Signed divide and remainder through the unit
        run_op("div -7/2", 3'd4, 1'b0, -64'sd7, 64'd2, 64'd3, 64'd1, -64'sd3, 1, 3);
        check_val("div mag a", cap_a, 64'd7);
        check_val("div mag b", cap_b, 64'd2);
        run_op("rem -7/2", 3'd6, 1'b0, -64'sd7, 64'd2, 64'd3, 64'd1, -64'sd1, 1, 3);

        // Divide-by-zero and overflow shortcuts
        run_op("divu 5/0", 3'd5, 1'b0, 64'd5, 64'd0, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1);
        run_op("remw /0", 3'd6, 1'b1, 64'h1_8000_0005, 64'd0, 64'd0, 64'd0, 64'hFFFF_FFFF_8000_0005, 0, 1);
        run_op("div ovf", 3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'd0, 64'd0, 64'h8000_0000_0000_0000, 0, 1);
        run_op("rem ovf", 3'd6, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'd0, 64'd0, 64'd0, 0, 1);
        run_op("divw ovf", 3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
               64'd0, 64'd0, 64'hFFFF_FFFF_8000_0000, 0, 1);

        // Multiplies
        run_op("mulhsu -1*2", 3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd2, 64'd0,
               64'hFFFF_FFFF_FFFF_FFFF, 1, 3);
        check_val("mulhsu mag a", cap_a, 64'd1);
        run_op("mulw", 3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFE, 64'd0,
               64'hFFFF_FFFF_FFFF_FFFE, 1, 3);
        run_op("mulhu", 3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1,
               64'd1, 1, 3);
        check_val("mulhu raw a", cap_a, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("mulh w ignored", 3'd1, 1'b1, 64'h1_0000_0000, 64'h1_0000_0000, 64'd0, 64'd1,
               64'd1, 1, 3);
        check_val("mulh full a", cap_a, 64'h1_0000_0000);

        // Flush in WAIT with unit_done in the same cycle
        model_en = 1'b0;
        @(negedge clk);
        s0            = start_cnt;
        bus.req_valid = 1'b1;
        bus.req_op    = 3'd5;
        bus.req_word  = 1'b0;
        bus.req_a     = 64'd10;
        bus.req_b     = 64'd3;
        wait_accept("flush op");
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        bus.flush = 1'b1;
        man_done  = 1'b1;
        mdl_lo    = 64'd3;
        mdl_hi    = 64'd1;
        @(negedge clk);
        bus.flush = 1'b0;
        man_done  = 1'b0;
        check_val("flush abort", 64'(unit_abort), 64'd1);
        check_val("flush no resp", 64'(bus.resp_valid), 64'd0);
        check_val("flush ready", 64'(bus.req_ready), 64'd1);
        @(negedge clk);
        check_val("abort one cycle", {62'd0, unit_abort, bus.resp_valid}, 64'd0);
        check_val("flush starts", 64'(start_cnt - s0), 64'd1);
        model_en = 1'b1;

        // Flush with a request in IDLE accepts nothing
        s0            = start_cnt;
        bus.req_valid = 1'b1;
        bus.flush     = 1'b1;
        bus.req_op    = 3'd5;
        bus.req_b     = 64'd0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;
        check_val("idle flush ready", 64'(bus.req_ready), 64'd1);
        @(negedge clk);
        check_val("idle flush quiet", {63'd0, bus.resp_valid}, 64'd0);
        check_val("idle flush starts", 64'(start_cnt - s0), 64'd0);

        // Response held while the pipeline stalls
        @(negedge clk);
        mdl_lo        = 64'd5;
        mdl_hi        = 64'd0;
        bus.req_valid = 1'b1;
        bus.req_op    = 3'd4;
        bus.req_word  = 1'b0;
        bus.req_a     = 64'd20;
        bus.req_b     = 64'd4;
        wait_accept("hold op");
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check_val("hold valid/ready", {62'd0, bus.resp_valid, bus.req_ready}, 64'd2);
            check_val("hold data", bus.resp_data, 64'd5);
            @(negedge clk);
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        check_val("hold released", {62'd0, bus.resp_valid, bus.req_ready}, 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
